refresh_scheduler: RTL and testbench

- Per-rank auto-refresh scheduler alongside the per-bank timing counters. It feeds the command scheduler FSM, which consumes its refresh request and drives FSM_REFRESH / precharge-all.
- Generates the tREFI tick and tracks postponed refreshes (DDR3 limit: 8).
- Requests REF opportunistically when the rank is idle, and urgently when the postpone budget is nearly exhausted.
- Blocks all commands for tRFC after each REF.

---
 rtl/refresh_scheduler.sv | 162 ++++++++++++++++
 tb/tb_refresh_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/refresh_scheduler.sv
// Per-rank auto-refresh scheduler: tREFI tick, postponed-refresh accounting, REF request and tRFC blocking.
// Optional back-to-back refresh bursts after an urgent REF are enabled with `define REF_BURST_EN.
module refresh_scheduler #(
  parameter int unsigned TREFI_CYCLES = 6240,
  parameter int unsigned TRFC_CYCLES  = 208,
  parameter int unsigned MAX_POSTPONE = 8,
  parameter int unsigned URGENT_LEVEL = 7,
  parameter int unsigned BANK_NUM     = 8,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init_done,
  input  logic [BANK_NUM-1:0] bank_idle,
  input  logic                sched_busy,
  input  logic                ref_ack,
  output logic                ref_req,
  output logic                ref_urgent,
  output logic                in_refresh,
  output logic [3:0]          pending_cnt,
  output logic [CNT_W-1:0]    tREF_counter,
  output logic                ref_overflow
);

  localparam int unsigned PEND_W = 4;
  localparam int unsigned RFC_W  = $clog2(TRFC_CYCLES + 1);

  localparam logic [PEND_W-1:0] PEND_MAX    = PEND_W'(MAX_POSTPONE);
  localparam logic [PEND_W-1:0] PEND_URG    = PEND_W'(URGENT_LEVEL);
  localparam logic [CNT_W-1:0]  TREF_RELOAD = CNT_W'(TREFI_CYCLES - 1);
  localparam logic [RFC_W-1:0]  RFC_RELOAD  = RFC_W'(TRFC_CYCLES - 1);
`ifdef REF_BURST_EN
  localparam logic [PEND_W-1:0] PEND_BURST  = PEND_W'(URGENT_LEVEL - 1);
`endif

  typedef enum logic [1:0] {WAIT_INIT, ARMED, REQ, RFC} state_t;

  state_t             state_q, state_nxt;
  logic [RFC_W-1:0]   rfc_q, rfc_nxt;
  logic [PEND_W-1:0]  pend_nxt;
  logic [CNT_W-1:0]   tref_nxt;
  logic               ovf_nxt;
  logic               burst_q, burst_nxt;
  logic               running_c, tick_c, ack_acc_c, idle_ok_c, urgent_lvl_c, rfc_done_c;
  logic               ref_req_nxt, ref_urgent_nxt, in_refresh_nxt;

  // Qualifiers derived from registered state
  always_comb begin
    running_c    = (state_q != WAIT_INIT);
    tick_c       = running_c && (tREF_counter == '0);
    ack_acc_c    = (state_q == REQ) && ref_ack;
    idle_ok_c    = (&bank_idle) && !sched_busy;
    urgent_lvl_c = (pending_cnt >= PEND_URG);
    rfc_done_c   = (state_q == RFC) && (rfc_q == '0);
  end

  // Interval timer, tRFC timer and postponed-refresh bookkeeping
  always_comb begin
    pend_nxt = pending_cnt;
    ovf_nxt  = ref_overflow;
    if (tick_c && !ack_acc_c) begin
      if (pending_cnt == PEND_MAX) begin
        ovf_nxt = 1'b1;
      end else begin
        pend_nxt = pending_cnt + PEND_W'(1);
      end
    end else if (ack_acc_c && !tick_c) begin
      pend_nxt = pending_cnt - PEND_W'(1);
    end

    if (!running_c || tick_c) begin
      tref_nxt = TREF_RELOAD;
    end else begin
      tref_nxt = tREF_counter - CNT_W'(1);
    end

    rfc_nxt = rfc_q;
    if (ack_acc_c) begin
      rfc_nxt = RFC_RELOAD;
    end else if ((state_q == RFC) && (rfc_q != '0)) begin
      rfc_nxt = rfc_q - RFC_W'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    burst_nxt = burst_q;
    case (state_q)
      WAIT_INIT: begin
        if (init_done) state_nxt = ARMED;
      end
      ARMED: begin
        if ((pending_cnt != '0) && (idle_ok_c || urgent_lvl_c)) state_nxt = REQ;
      end
      REQ: begin
        if (ack_acc_c) state_nxt = RFC;
      end
      RFC: begin
        if (rfc_done_c) begin
`ifdef REF_BURST_EN
          // Burst keeps refreshing regardless of traffic until the backlog is gone
          if (burst_q) begin
            if (pending_cnt != '0) begin
              state_nxt = REQ;
            end else begin
              state_nxt = ARMED;
              burst_nxt = 1'b0;
            end
          end else if ((pending_cnt != '0) && (pending_cnt >= PEND_BURST)) begin
            state_nxt = REQ;
            burst_nxt = 1'b1;
          end else begin
            state_nxt = ARMED;
          end
`else
          state_nxt = ARMED;
`endif
        end
      end
      default: state_nxt = WAIT_INIT;
    endcase
  end

  // Output decode, registered alongside the state
  always_comb begin
    ref_req_nxt    = (state_nxt == REQ);
    ref_urgent_nxt = (state_nxt == REQ) && ((pend_nxt >= PEND_URG) || burst_nxt);
    in_refresh_nxt = (state_nxt == RFC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_INIT;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rfc_q        <= '0;
      burst_q      <= 1'b0;
      pending_cnt  <= '0;
      tREF_counter <= TREF_RELOAD;
      ref_overflow <= 1'b0;
      ref_req      <= 1'b0;
      ref_urgent   <= 1'b0;
      in_refresh   <= 1'b0;
    end else begin
      rfc_q        <= rfc_nxt;
      burst_q      <= burst_nxt;
      pending_cnt  <= pend_nxt;
      tREF_counter <= tref_nxt;
      ref_overflow <= ovf_nxt;
      ref_req      <= ref_req_nxt;
      ref_urgent   <= ref_urgent_nxt;
      in_refresh   <= in_refresh_nxt;
    end
  end

endmodule

// File: tb/tb_refresh_scheduler.sv
// Self-checking bench for refresh_scheduler: directed scenarios plus random traffic against a behavioural model.
module tb_refresh_scheduler;

  localparam int TREFI = 100;
  localparam int TRFC  = 10;
  localparam int MAXP  = 8;
  localparam int URG   = 7;

  localparam int S_WAIT  = 0;
  localparam int S_ARMED = 1;
  localparam int S_REQ   = 2;
  localparam int S_RFC   = 3;

  logic        clk;
  logic        rst;
  logic        init_done;
  logic [7:0]  bank_idle;
  logic        sched_busy;
  logic        ref_ack;
  logic        ref_req;
  logic        ref_urgent;
  logic        in_refresh;
  logic [3:0]  pending_cnt;
  logic [15:0] tREF_counter;
  logic        ref_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: time since arming, refresh backlog, ack timestamp
  int m_state = S_WAIT;
  int m_run   = 0;
  int m_pend  = 0;
  int m_ovf   = 0;
  int m_ack   = 0;
  int m_burst = 0;

  refresh_scheduler #(
    .TREFI_CYCLES(TREFI),
    .TRFC_CYCLES (TRFC),
    .MAX_POSTPONE(MAXP),
    .URGENT_LEVEL(URG),
    .BANK_NUM    (8),
    .CNT_W       (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .init_done   (init_done),
    .bank_idle   (bank_idle),
    .sched_busy  (sched_busy),
    .ref_ack     (ref_ack),
    .ref_req     (ref_req),
    .ref_urgent  (ref_urgent),
    .in_refresh  (in_refresh),
    .pending_cnt (pending_cnt),
    .tREF_counter(tREF_counter),
    .ref_overflow(ref_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_update();
    bit tick, acc, idle_ok;
    int p, old_state;
    if (rst) begin
      m_state = S_WAIT; m_run = 0; m_pend = 0; m_ovf = 0; m_ack = 0; m_burst = 0;
    end else begin
      old_state = m_state;
      tick    = (m_state != S_WAIT) && ((m_run % TREFI) == TREFI - 1);
      acc     = (m_state == S_REQ) && ref_ack;
      idle_ok = (bank_idle == 8'hFF) && !sched_busy;
      p = m_pend;
      if (tick && !acc) begin
        if (m_pend == MAXP) m_ovf = 1;
        else p = m_pend + 1;
      end else if (acc && !tick) begin
        p = m_pend - 1;
      end
      case (m_state)
        S_WAIT:  if (init_done) m_state = S_ARMED;
        S_ARMED: if (m_pend > 0 && (idle_ok || m_pend >= URG)) m_state = S_REQ;
        S_REQ:   if (acc) begin m_state = S_RFC; m_ack = m_run; end
        default: begin
          if (m_run - m_ack == TRFC) begin
`ifdef REF_BURST_EN
            if (m_burst != 0) begin
              if (m_pend > 0) m_state = S_REQ;
              else begin m_state = S_ARMED; m_burst = 0; end
            end else if (m_pend > 0 && m_pend >= URG - 1) begin
              m_state = S_REQ; m_burst = 1;
            end else begin
              m_state = S_ARMED;
            end
`else
            m_state = S_ARMED;
`endif
          end
        end
      endcase
      if (old_state != S_WAIT) m_run++;
      m_pend = p;
    end
  endtask

  task automatic compare();
    int exp_tref;
    exp_tref = (m_state == S_WAIT) ? TREFI - 1 : TREFI - 1 - (m_run % TREFI);
    chk("ref_req",      32'(ref_req),      32'(m_state == S_REQ));
    chk("ref_urgent",   32'(ref_urgent),   32'((m_state == S_REQ) && (m_pend >= URG || m_burst != 0)));
    chk("in_refresh",   32'(in_refresh),   32'(m_state == S_RFC));
    chk("pending_cnt",  32'(pending_cnt),  32'(m_pend));
    chk("tREF_counter", 32'(tREF_counter), 32'(exp_tref));
    chk("ref_overflow", 32'(ref_overflow), 32'(m_ovf));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  initial begin
    int n;
    int inrf;
    rst = 1'b1; init_done = 1'b0; bank_idle = 8'hFF; sched_busy = 1'b0; ref_ack = 1'b0;
    repeat (3) step();
    chk("rst_tref", 32'(tREF_counter), 32'd99);
    chk("rst_pend", 32'(pending_cnt), 32'd0);
    chk("rst_req",  32'(ref_req), 32'd0);

    // First interval: tick after 100 running cycles, then request and one REF
    rst = 1'b0; init_done = 1'b1;
    step();
    repeat (99) step();
    chk("s1_tref_zero", 32'(tREF_counter), 32'd0);
    chk("s1_pend_pre",  32'(pending_cnt), 32'd0);
    step();
    chk("s1_pend_tick", 32'(pending_cnt), 32'd1);
    chk("s1_tref_rld",  32'(tREF_counter), 32'd99);
    chk("s1_req_low",   32'(ref_req), 32'd0);
    step();
    chk("s1_req_high",  32'(ref_req), 32'd1);
    ref_ack = 1'b1;
    step();
    ref_ack = 1'b0;
    chk("s1_req_drop",  32'(ref_req), 32'd0);
    chk("s1_pend_ack",  32'(pending_cnt), 32'd0);
    inrf = in_refresh ? 1 : 0;
    repeat (12) begin
      step();
      if (in_refresh) inrf++;
    end
    chk("s1_rfc_len", 32'(inrf), 32'd10);

    // Busy traffic: backlog builds up to saturation
    sched_busy = 1'b1;
    n = 0;
    while (pending_cnt != 4'd8 && n < 1000) begin step(); n++; end
    chk("s2_pend8", 32'(pending_cnt), 32'd8);
    chk("s2_ovf0",  32'(ref_overflow), 32'd0);
    chk("s2_req",   32'(ref_req), 32'd1);
    chk("s2_urg",   32'(ref_urgent), 32'd1);
    n = 0;
    while (!ref_overflow && n < 200) begin step(); n++; end
    chk("s3_ovf1",  32'(ref_overflow), 32'd1);
    chk("s3_pend8", 32'(pending_cnt), 32'd8);
    chk("s3_tref",  32'(tREF_counter), 32'd99);

    // Acknowledge every request while traffic stays busy
    repeat (90) begin
      ref_ack = (m_state == S_REQ);
      step();
    end
    ref_ack = 1'b0;
`ifdef REF_BURST_EN
    chk("s5_burst_pend", 32'(pending_cnt), 32'd0);
`else
    chk("s5_armed_pend", 32'(pending_cnt), 32'd6);
`endif
    chk("s5_req",      32'(ref_req), 32'd0);
    chk("s5_rfc",      32'(in_refresh), 32'd0);
    chk("s5_ovf_kept", 32'(ref_overflow), 32'd1);

    // Drain, then build a backlog of 3 and ack on a tick cycle
    sched_busy = 1'b0;
    n = 0;
    while (pending_cnt != 4'd0 && n < 600) begin
      ref_ack = (m_state == S_REQ);
      step(); n++;
    end
    ref_ack = 1'b0;
    chk("s4_drained", 32'(pending_cnt), 32'd0);
    sched_busy = 1'b1;
    n = 0;
    while (pending_cnt != 4'd3 && n < 400) begin step(); n++; end
    chk("s4_pend3", 32'(pending_cnt), 32'd3);
    sched_busy = 1'b0;
    step();
    chk("s4_req", 32'(ref_req), 32'd1);
    n = 0;
    while (tREF_counter != 16'd0 && n < 150) begin step(); n++; end
    chk("s4_tick_cycle", 32'(tREF_counter), 32'd0);
    ref_ack = 1'b1;
    step();
    ref_ack = 1'b0;
    chk("s4_pend_same", 32'(pending_cnt), 32'd3);
    chk("s4_in_rfc",    32'(in_refresh), 32'd1);

    // Stray acks in RFC and ARMED are ignored
    ref_ack = 1'b1;
    step();
    ref_ack = 1'b0;
    chk("s6_ack_rfc_pend", 32'(pending_cnt), 32'd3);
    chk("s6_ack_rfc_rfc",  32'(in_refresh), 32'd1);
    sched_busy = 1'b1;
    repeat (10) step();
    chk("s6_rfc_over", 32'(in_refresh), 32'd0);
    ref_ack = 1'b1;
    step();
    ref_ack = 1'b0;
    chk("s6_ack_armed_pend", 32'(pending_cnt), 32'd3);
    chk("s6_ack_armed_req",  32'(ref_req), 32'd0);

    // Reset in the middle of tRFC
    sched_busy = 1'b0;
    step();
    chk("s7_req", 32'(ref_req), 32'd1);
    ref_ack = 1'b1;
    step();
    ref_ack = 1'b0;
    repeat (4) step();
    chk("s7_rfc5", 32'(in_refresh), 32'd1);
    rst = 1'b1;
    step();
    chk("s7_rst_rfc",  32'(in_refresh), 32'd0);
    chk("s7_rst_pend", 32'(pending_cnt), 32'd0);
    chk("s7_rst_tref", 32'(tREF_counter), 32'd99);
    chk("s7_rst_ovf",  32'(ref_overflow), 32'd0);
    rst = 1'b0; init_done = 1'b0;
    repeat (20) step();
    chk("s7_wait_hold", 32'(tREF_counter), 32'd99);

    // Random traffic, light load with occasional reset
    repeat (4000) begin
      rst        = ($urandom_range(0, 399) == 0);
      init_done  = ($urandom_range(0, 7) != 0);
      bank_idle  = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom);
      sched_busy = ($urandom_range(0, 2) == 0);
      ref_ack    = (m_state == S_REQ) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      step();
    end

    // Random traffic, heavy load to exercise saturation
    rst = 1'b0;
    repeat (3000) begin
      init_done  = ($urandom_range(0, 1) != 0);
      bank_idle  = 8'($urandom);
      sched_busy = ($urandom_range(0, 9) != 0);
      ref_ack    = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
